// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, entry defaults and default lookup for reg_file_ctrl
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

    localparam logic [7:0] REG2_DEF = 8'h20;
    localparam logic [7:0] REG3_DEF = 8'h08;

    function automatic logic [7:0] def_val(input int idx);
        case (idx)
            2:       return REG2_DEF;
            3:       return REG3_DEF;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/regfile_rd_pipe.sv
// rtl/regfile_rd_pipe.sv - RD_LAT-stage delay line for read data, valid, address error and parity error
module regfile_rd_pipe #(
    parameter int WIDTH  = 8,
    parameter int RD_LAT = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             InVld,
    input  logic [WIDTH-1:0] InData,
    input  logic             InErr,
    input  logic             InPErr,
    output logic             OutVld,
    output logic [WIDTH-1:0] OutData,
    output logic             OutErr,
    output logic             OutPErr
);

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] err_q;
    logic [RD_LAT-1:0] perr_q;
    logic [WIDTH-1:0]  data_q [RD_LAT];

    // Shift flags every cycle; data only moves with a valid so the output holds between reads
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vld_q  <= '0;
            err_q  <= '0;
            perr_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= InVld;
            err_q[0]  <= InErr;
            perr_q[0] <= InPErr;
            if (InVld) begin
                data_q[0] <= InData;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                err_q[i]  <= err_q[i-1];
                perr_q[i] <= perr_q[i-1];
                if (vld_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign OutVld  = vld_q[RD_LAT-1];
    assign OutErr  = err_q[RD_LAT-1];
    assign OutPErr = perr_q[RD_LAT-1];
    assign OutData = data_q[RD_LAT-1];

endmodule

// File: rtl/reg_file_ctrl.sv
// rtl/reg_file_ctrl.sv - masked-write register file with read pipeline and clear sequencer; optional REGFILE_PARITY_EN
module reg_file_ctrl
    import regfile_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int ADDR    = 4,
    parameter int NUM_CFG = 4,
    parameter int RD_LAT  = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     WrEn,
    input  logic                     RdEn,
    input  logic [ADDR-1:0]          Address,
    input  logic [WIDTH-1:0]         WrData,
    input  logic [WIDTH-1:0]         WrMask,
    input  logic                     ClrReq,
    output logic [WIDTH-1:0]         RdData,
    output logic                     RdData_VLD,
    output logic                     AddrErr,
    output logic                     Busy,
    output logic [NUM_CFG*WIDTH-1:0] CfgRegs,
    output logic                     RdPErr
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR:0]   DEPTH_CMP = (ADDR+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    rf_state_e        state;
    rf_state_e        state_nxt;
    logic [IDX_W-1:0] clr_idx;
    logic [IDX_W-1:0] addr_idx;
    logic             idle;
    logic             in_range;
    logic             wr_ok;
    logic             rd_ok;
    logic             clr_last;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] wr_merged;
    logic             rd_perr;
    logic             pipe_err;
    logic             wr_err_q;

    assign addr_idx  = Address[IDX_W-1:0];
    assign in_range  = ({1'b0, Address} < DEPTH_CMP);
    assign clr_last  = (clr_idx == LAST_IDX);
    assign wr_ok     = idle & WrEn & in_range;
    assign rd_ok     = idle & RdEn;
    assign rd_word   = in_range ? mem[addr_idx] : '0;
    assign wr_merged = (mem[addr_idx] & ~WrMask) | (WrData & WrMask);

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and access gating; ClrReq is only honoured from IDLE
    always_comb begin
        state_nxt = state;
        idle      = 1'b0;
        Busy      = 1'b0;
        case (state)
            IDLE: begin
                idle = 1'b1;
                if (ClrReq) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                Busy = 1'b1;
                if (clr_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Clear index walks 0..DEPTH-1, one entry per cycle
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            clr_idx <= '0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_last ? '0 : clr_idx + 1'b1;
        end
    end

    // Storage: defaults on reset, sequenced defaults while clearing, masked write otherwise
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= WIDTH'(def_val(i));
            end
        end else if (state == CLEAR) begin
            mem[clr_idx] <= WIDTH'(def_val(int'(clr_idx)));
        end else if (wr_ok) begin
            mem[addr_idx] <= wr_merged;
        end
    end

`ifdef REGFILE_PARITY_EN
    logic [DEPTH-1:0] par;

    // Even parity tracks every storage update
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                par[i] <= ^(WIDTH'(def_val(i)));
            end
        end else if (state == CLEAR) begin
            par[clr_idx] <= ^(WIDTH'(def_val(int'(clr_idx))));
        end else if (wr_ok) begin
            par[addr_idx] <= ^wr_merged;
        end
    end

    assign rd_perr = rd_ok & in_range & ((^rd_word) ^ par[addr_idx]);
`else
    assign rd_perr = 1'b0;
`endif

    // Write-side address error reports one cycle after the request
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= idle & WrEn & ~in_range;
        end
    end

    regfile_rd_pipe #(
        .WIDTH  (WIDTH),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .CLK     (CLK),
        .RST     (RST),
        .InVld   (rd_ok),
        .InData  (rd_word),
        .InErr   (rd_ok & ~in_range),
        .InPErr  (rd_perr),
        .OutVld  (RdData_VLD),
        .OutData (RdData),
        .OutErr  (pipe_err),
        .OutPErr (RdPErr)
    );

    assign AddrErr = pipe_err | wr_err_q;

    // Flat export of the low configuration entries
    always_comb begin
        CfgRegs = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            CfgRegs[i*WIDTH +: WIDTH] = mem[i];
        end
    end

endmodule
